// File: rtl/branch_pkg.sv
// Shared definitions for the decode-stage branch resolution unit.
package branch_pkg;

    // Branch opcodes in inst[15:12]
    localparam logic [3:0] OP_B  = 4'hC;
    localparam logic [3:0] OP_BR = 4'hD;

    // Condition codes in inst[11:9]
    typedef enum logic [2:0] {
        CC_NE     = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GTE    = 3'b100,
        CC_LTE    = 3'b101,
        CC_OV     = 3'b110,
        CC_UNCOND = 3'b111
    } cond_e;

    // Resolution FSM: IDLE resolves immediately, WAIT holds the front end
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } br_state_e;

    // PC-relative offset: signed 9-bit halfword displacement scaled to bytes
    function automatic logic [15:0] b_offset(input logic [8:0] imm9);
        return {{6{imm9[8]}}, imm9, 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation against flags {Z,V,N}.
module branch_cond_eval
    import branch_pkg::*;
(
    input  cond_e      ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;
    assign z = flags[2];
    assign v = flags[1];
    assign n = flags[0];

    // Map condition code to the flag predicate
    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:     taken = ~z;
            CC_EQ:     taken = z;
            CC_GT:     taken = ~z & ~n;
            CC_LT:     taken = n;
            CC_GTE:    taken = z | (~z & ~n);
            CC_LTE:    taken = n | z;
            CC_OV:     taken = v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Decode-stage branch resolution: evaluates B/BR against flags, computes the
// real target, drives predictor update strobes and stalls on flag/register
// hazards.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int FLAG_WAIT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IF_ID_valid,
    input  logic [15:0]      IF_ID_inst,
    input  logic [15:0]      IF_ID_PC_next,
    input  logic [1:0]       IF_ID_prediction,
    input  logic [15:0]      IF_ID_predicted_target,
    input  logic             ID_EX_sets_flags,
    input  logic [2:0]       flags,
    input  logic [15:0]      BR_reg_data,
    input  logic             BR_reg_hazard,
    output logic             is_branch,
    output logic             branch_stall,
    output logic             actual_taken,
    output logic [15:0]      actual_target,
    output logic             wen_BTB,
    output logic             wen_BHT,
    output logic             update_PC,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int WCW = $clog2(FLAG_WAIT + 1);

    br_state_e        state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic [3:0]  opcode;
    cond_e       ccc;
    logic        is_br_reg;
    logic        hazard;
    logic [15:0] branch_target;
    logic        cond_taken;
    logic        stall, res, res_g;
    logic        mispredicted, miscomputed;

    assign opcode    = IF_ID_inst[15:12];
    assign ccc       = cond_e'(IF_ID_inst[11:9]);
    assign is_br_reg = (opcode == OP_BR);
    assign is_branch = IF_ID_valid & ((opcode == OP_B) | is_br_reg);

    assign branch_target = is_br_reg ? BR_reg_data
                                     : IF_ID_PC_next + b_offset(IF_ID_inst[8:0]);

    // Unconditional branches never depend on flags still in flight
    assign hazard = is_branch & (((ccc != CC_UNCOND) & ID_EX_sets_flags) |
                                 (is_br_reg & BR_reg_hazard));

    branch_cond_eval u_cond (
        .ccc   (ccc),
        .flags (flags),
        .taken (cond_taken)
    );

    // Resolution FSM next state; EX holds a bubble during WAIT so flag
    // writes from EX are not rechecked there
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall      = 1'b0;
        res        = 1'b0;
        case (state_q)
            IDLE: begin
                if (hazard) begin
                    stall      = 1'b1;
                    state_d    = WAIT;
                    wait_cnt_d = WCW'(FLAG_WAIT - 1);
                end else if (is_branch) begin
                    res = 1'b1;
                end
            end
            WAIT: begin
                if ((wait_cnt_q != '0) || (is_br_reg && BR_reg_hazard)) begin
                    stall = 1'b1;
                    if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 1'b1;
                end else if (is_branch) begin
                    res     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces the stall and strobes low at once, even mid-WAIT
    assign res_g        = res & ~rst;
    assign branch_stall = stall & ~rst;

    assign mispredicted = IF_ID_prediction[1] != cond_taken;
    assign miscomputed  = IF_ID_predicted_target != branch_target;

    // Resolve-cycle outputs; all quiet outside a resolve cycle
    always_comb begin
        actual_taken  = 1'b0;
        actual_target = 16'h0000;
        wen_BHT       = 1'b0;
        wen_BTB       = 1'b0;
        update_PC     = 1'b0;
        if (res_g) begin
            actual_taken  = cond_taken;
            actual_target = cond_taken ? branch_target : IF_ID_PC_next;
            wen_BHT       = mispredicted;
            wen_BTB       = cond_taken & miscomputed;
            update_PC     = mispredicted | (cond_taken & miscomputed);
        end
    end

    // Saturating performance counters
    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (res_g && (bcnt_q != '1))     bcnt_d = bcnt_q + 1'b1;
        if (update_PC && (mcnt_q != '1)) mcnt_d = mcnt_q + 1'b1;
    end

    // State, wait counter and performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            bcnt_q     <= '0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bcnt_q     <= bcnt_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
Decode-stage branch resolution unit. It is the consumer/producer counterpart of the Fetch stage's dynamic branch predictor. It takes the IF/ID pipeline fields of the instruction in decode, evaluates the branch condition against the flag register and computes the real target. It drives actual_taken, actual_target, wen_BTB, wen_BHT and update_PC back to Fetch, and stalls the front end while flags or the BR source register are not yet valid.

Parameters:
FLAG_WAIT, 1, stall cycles inserted when the instruction in EX writes flags (must be >=1)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
IF_ID_valid  input  1  IF/ID holds a valid instruction
IF_ID_inst  input  16  instruction in decode
IF_ID_PC_next  input  16  PC+2 of the instruction in decode
IF_ID_prediction  input  2  2-bit predictor state captured at fetch; [1]=predicted taken
IF_ID_predicted_target  input  16  BTB target captured at fetch
ID_EX_sets_flags  input  1  instruction in EX writes Z/V/N
flags  input  3  flag register {Z,V,N}
BR_reg_data  input  16  source register value for BR
BR_reg_hazard  input  1  BR source register not yet available
is_branch  output  1  valid B/BR in decode
branch_stall  output  1  hold PC and IF/ID, inject bubble into ID/EX
actual_taken  output  1  resolved direction
actual_target  output  16  redirect address
wen_BTB  output  1  BTB write strobe
wen_BHT  output  1  BHT update strobe
update_PC  output  1  redirect Fetch to actual_target and flush IF/ID
branch_count  output  CNT_W  resolved branches
mispredict_count  output  CNT_W  redirects issued

Behaviour:
- Decode: opcode=inst[15:12]. 4'hC=B, 4'hD=BR. ccc=inst[11:9]. imm9=inst[8:0], signed.
- is_branch = IF_ID_valid & (opcode==C | opcode==D).
- branch_target: B gives IF_ID_PC_next + (sext(imm9)<<1), mod 2^16. BR gives BR_reg_data.
- Conditions by ccc:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0&N=0
  - 011 LT: N=1
  - 100 GTE: Z=1|(Z=0&N=0)
  - 101 LTE: N=1|Z=1
  - 110 OV: V=1
  - 111 unconditional: always taken, no flag dependency
- hazard = is_branch & ((ccc!=111 & ID_EX_sets_flags) | (opcode==D & BR_reg_hazard)).
- FSM states: IDLE, WAIT. wait_cnt is a register of width clog2(FLAG_WAIT+1).
  - IDLE, hazard: branch_stall=1, no strobes; next state WAIT, wait_cnt<=FLAG_WAIT-1.
  - IDLE, is_branch and no hazard: resolve this cycle, stay IDLE.
  - WAIT, (wait_cnt!=0 | (opcode==D & BR_reg_hazard)): branch_stall=1; wait_cnt decrements, saturating at 0.
  - WAIT, otherwise: resolve this cycle, next state IDLE. ID_EX_sets_flags is ignored in WAIT because EX holds a bubble.
- Stall length: exactly FLAG_WAIT cycles for a flag hazard, extended while BR_reg_hazard holds.
- Resolve cycle (res=1), all outputs combinational:
  - actual_taken = cond(flags).
  - mispredicted = IF_ID_prediction[1] != actual_taken.
  - miscomputed = IF_ID_predicted_target != branch_target.
  - actual_target = actual_taken ? branch_target : IF_ID_PC_next.
  - wen_BHT = mispredicted.
  - wen_BTB = actual_taken & miscomputed.
  - update_PC = mispredicted | (actual_taken & miscomputed).
- Outside a resolve cycle: actual_taken, wen_*, update_PC are 0 and actual_target=0x0000.
- Counters: branch_count+1 per resolve cycle; mispredict_count+1 per update_PC. Both saturate at all-ones.
- Reset: state IDLE, wait_cnt 0, counters 0. branch_stall drops immediately, including when reset is asserted mid-WAIT.
- IF_ID_valid=0: no hazard, no strobes. The FSM stays in IDLE, or in WAIT until it resolves.

Decomposition:
- Package branch_pkg: opcode constants OP_B=4'hC, OP_BR=4'hD; ccc enum (NE, EQ, GT, LT, GTE, LTE, OV, UNCOND); FSM state enum {IDLE, WAIT}.
- Sub-module branch_cond_eval: combinational, ccc + flags -> taken.

Test Plan:
1. inst=0xC205 (B EQ, imm 5), PC_next=0x0010, flags Z=1, prediction=00, predicted_target=0x0000 -> actual_taken=1, actual_target=0x001A, update_PC=1, wen_BHT=1, wen_BTB=1, branch_stall=0, both counters =1.
2. Same inst, prediction=11, predicted_target=0x001A, Z=1 -> actual_taken=1, update_PC=0, wen_BHT=0, wen_BTB=0; branch_count increments, mispredict_count unchanged.
3. Same inst, prediction=10, Z=0 -> actual_taken=0, actual_target=0x0010, update_PC=1, wen_BHT=1, wen_BTB=0.
4. ID_EX_sets_flags=1 with the inst from 1; FLAG_WAIT=1 -> cycle0: branch_stall=1, no strobes; cycle1: resolves using the updated flags. Repeat with FLAG_WAIT=3 -> exactly 3 stall cycles.
5. inst=0xCFFF (B UNCOND, imm -1), PC_next=0x0000, ID_EX_sets_flags=1 -> no stall, actual_target=0xFFFE (wraps), actual_taken=1.
6. BR (opcode D) with BR_reg_hazard held 3 cycles, then BR_reg_data=0x1234 -> 3 stall cycles, then actual_target=0x1234. Rerun and assert rst mid-WAIT -> branch_stall=0 immediately, counters=0.
